// File: rtl/completion_arbiter.sv
// Completion arbiter: per-source result FIFOs feeding one reorder-buffer
// completion port. The port has no backpressure, so each cycle the
// round-robin arbiter grants at most one FIFO head and that FIFO pops.
// The complete_* outputs depend only on registered state, which keeps the
// producer inputs off the ROB timing path.
module completion_arbiter #(
   parameter int NUM_SRC         = 3,
   parameter int FIFO_DEPTH      = 2,
   parameter int ROB_ENTRY_WIDTH = 2,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic [NUM_SRC-1:0]                            src_valid_i,
   output logic [NUM_SRC-1:0]                            src_ready_o,
   input  logic [NUM_SRC-1:0][ROB_ENTRY_WIDTH-1:0]       src_idx_i,
   input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]            src_data_i,
   input  logic [NUM_SRC-1:0]                            src_excp_i,
   output logic                                          complete_valid_o,
   output logic [ROB_ENTRY_WIDTH-1:0]                    complete_idx_o,
   output logic [DATA_WIDTH-1:0]                         complete_data_o,
   output logic                                          complete_excp_o,
   output logic                                          busy_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = $clog2(NUM_SRC);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [RR_W-1:0]  LAST_SRC = RR_W'(NUM_SRC - 1);
   localparam logic [RR_W:0]    SRC_MOD  = (RR_W + 1)'(NUM_SRC);

   // Per-source FIFO storage and pointers
   logic [ROB_ENTRY_WIDTH-1:0] idx_mem_q  [NUM_SRC][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      data_mem_q [NUM_SRC][FIFO_DEPTH];
   logic                       excp_mem_q [NUM_SRC][FIFO_DEPTH];
   logic [PTR_W-1:0]           rd_ptr_q   [NUM_SRC];
   logic [PTR_W-1:0]           wr_ptr_q   [NUM_SRC];
   logic [CNT_W-1:0]           count_q    [NUM_SRC];

   // Arbitration state
   logic [RR_W-1:0]            rr_q;
   logic [RR_W-1:0]            rr_d;
   logic                       grant_valid;
   logic [RR_W-1:0]            winner;
   logic [RR_W:0]              cand_sum;
   logic [RR_W-1:0]            cand;

   logic [NUM_SRC-1:0]         nonempty;
   logic [NUM_SRC-1:0]         push;
   logic [NUM_SRC-1:0]         pop;

   // FIFO status: ready comes from the registered count only, so a pop in
   // this cycle does not open a slot for a push in the same cycle.
   always_comb begin
      nonempty    = '0;
      src_ready_o = '0;
      push        = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         nonempty[s]    = (count_q[s] != '0);
         src_ready_o[s] = (count_q[s] != CNT_FULL);
         push[s]        = src_valid_i[s] && src_ready_o[s];
      end
   end

   assign busy_o = |nonempty;

   // Round-robin search starting at rr_q; first non-empty FIFO wins.
   always_comb begin
      grant_valid = 1'b0;
      winner      = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand_sum = {1'b0, rr_q} + (RR_W + 1)'(k);
         if (cand_sum >= SRC_MOD) begin
            cand_sum = cand_sum - SRC_MOD;
         end
         cand = cand_sum[RR_W-1:0];
         if (!grant_valid && nonempty[cand]) begin
            grant_valid = 1'b1;
            winner      = cand;
         end
      end
   end

   // Next search start is the source after the winner, wrapping at NUM_SRC.
   always_comb begin
      rr_d = rr_q;
      if (grant_valid) begin
         rr_d = (winner == LAST_SRC) ? '0 : winner + RR_W'(1);
      end
   end

   // Pop decode: only the granted FIFO advances its read pointer.
   always_comb begin
      pop = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         pop[s] = grant_valid && (winner == RR_W'(s));
      end
   end

   // Completion port driven from the winner's head; zeros when idle.
   always_comb begin
      complete_valid_o = grant_valid;
      complete_idx_o   = '0;
      complete_data_o  = '0;
      complete_excp_o  = 1'b0;
      if (grant_valid) begin
         complete_idx_o  = idx_mem_q[winner][rd_ptr_q[winner]];
         complete_data_o = data_mem_q[winner][rd_ptr_q[winner]];
         complete_excp_o = excp_mem_q[winner][rd_ptr_q[winner]];
      end
   end

   // FIFO storage, pointers and occupancy; reset discards in-flight results.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            rd_ptr_q[s] <= '0;
            wr_ptr_q[s] <= '0;
            count_q[s]  <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
               idx_mem_q[s][d]  <= '0;
               data_mem_q[s][d] <= '0;
               excp_mem_q[s][d] <= 1'b0;
            end
         end
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
               idx_mem_q[s][wr_ptr_q[s]]  <= src_idx_i[s];
               data_mem_q[s][wr_ptr_q[s]] <= src_data_i[s];
               excp_mem_q[s][wr_ptr_q[s]] <= src_excp_i[s];
               wr_ptr_q[s]                <= wr_ptr_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
               rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
            end
            case ({push[s], pop[s]})
               2'b10:   count_q[s] <= count_q[s] + CNT_W'(1);
               2'b01:   count_q[s] <= count_q[s] - CNT_W'(1);
               default: count_q[s] <= count_q[s];
            endcase
         end
      end
   end

   // Round-robin pointer; held when nothing is granted.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: tb/tb_completion_arbiter.sv
// Bench for completion_arbiter: directed stimulus, expected completions
// queued in hand-derived grant order, a negedge monitor pops and compares.
module tb_completion_arbiter;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        src_valid;
   logic [2:0]        src_ready;
   logic [2:0][1:0]   src_idx;
   logic [2:0][31:0]  src_data;
   logic [2:0]        src_excp;
   logic              cv;
   logic [1:0]        cidx;
   logic [31:0]       cdata;
   logic              cexcp;
   logic              busy;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] data;
      logic        excp;
   } comp_t;

   comp_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   completion_arbiter #(
      .NUM_SRC(3), .FIFO_DEPTH(2), .ROB_ENTRY_WIDTH(2), .DATA_WIDTH(32)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_n),
      .src_valid_i      (src_valid),
      .src_ready_o      (src_ready),
      .src_idx_i        (src_idx),
      .src_data_i       (src_data),
      .src_excp_i       (src_excp),
      .complete_valid_o (cv),
      .complete_idx_o   (cidx),
      .complete_data_o  (cdata),
      .complete_excp_o  (cexcp),
      .busy_o           (busy)
   );

   // Scoreboard monitor: every completion must match the queue head.
   always @(negedge clk) begin
      comp_t e;
      if (rst_n === 1'b1 && cv !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_completion: got idx=%0h data=%0h excp=%0b, expected none",
                     cidx, cdata, cexcp);
         end else begin
            e = exp_q.pop_front();
            if (cv !== 1'b1 || {cidx, cdata, cexcp} !== e) begin
               failures++;
               $display("FAIL completion: got idx=%0h data=%0h excp=%0b, expected idx=%0h data=%0h excp=%0b",
                        cidx, cdata, cexcp, e.idx, e.data, e.excp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_src;
      src_valid = '0;
      src_idx   = '0;
      src_data  = '0;
      src_excp  = '0;
   endtask

   task automatic drive(input int s, input logic [1:0] idx, input logic [31:0] data,
                        input logic excp, input bit expect_it);
      comp_t c;
      src_valid[s] = 1'b1;
      src_idx[s]   = idx;
      src_data[s]  = data;
      src_excp[s]  = excp;
      c.idx  = idx;
      c.data = data;
      c.excp = excp;
      if (expect_it) exp_q.push_back(c);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      idle_src();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int max);
      int i = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && i < max) begin
         tick();
         i++;
      end
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_busy_low"}, busy, 0);
   endtask

   function automatic comp_t item(input int s, input int k);
      comp_t c;
      c.idx  = 2'((s + k) % 4);
      c.data = (s == 2) ? 32'(k + 1) : 32'((s + 1) * 4096 + k + 1);
      c.excp = 1'b0;
      return c;
   endfunction

   // All three sources stream n items each from an empty, rr=0 state.
   // Saturated round-robin completes s0 k, s1 k, s2 k for k = 0..n-1,
   // one completion per cycle from the cycle after the first push.
   task automatic run_streams(input int n, input bit bp);
      int    ptr [3];
      comp_t c;
      for (int s = 0; s < 3; s++) ptr[s] = 0;
      for (int k = 0; k < n; k++)
         for (int s = 0; s < 3; s++) exp_q.push_back(item(s, k));
      for (int cyc = 0; cyc <= 3 * n; cyc++) begin
         for (int s = 0; s < 3; s++) begin
            if (ptr[s] < n) begin
               c = item(s, ptr[s]);
               drive(s, c.idx, c.data, c.excp, 1'b0);
               if (src_ready[s]) ptr[s]++;
            end else begin
               src_valid[s] = 1'b0;
            end
         end
         if (cyc >= 1) check("stream_valid_every_cycle", cv, 1);
         if (bp && cyc == 2) check("bp_ready2_low_at_full", src_ready[2], 0);
         if (bp && cyc == 3) check("bp_ready2_still_low", src_ready[2], 0);
         if (bp && cyc == 4) check("bp_ready2_recovers", src_ready[2], 1);
         tick();
      end
      idle_src();
      check("stream_queue_empty", exp_q.size(), 0);
      check("stream_busy_low", busy, 0);
   endtask

   initial begin
      idle_src();

      // Reset values and first-transaction latency
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("reset_valid", cv, 0);
      check("reset_idx", cidx, 0);
      check("reset_data", cdata, 0);
      check("reset_excp", cexcp, 0);
      check("reset_busy", busy, 0);
      check("reset_ready", src_ready, 3'b111);
      drive(0, 2'd2, 32'hDEADBEEF, 1'b0, 1'b1);
      tick();
      idle_src();
      check("lat_valid", cv, 1);
      check("lat_idx", cidx, 2);
      check("lat_data", cdata, 32'hDEADBEEF);
      check("lat_busy", busy, 1);
      tick();
      check("lat_busy_after", busy, 0);
      check("lat_valid_after", cv, 0);

      // Simultaneous push, round-robin order, then wrap back to rr=0
      do_reset();
      drive(0, 2'd0, 32'hA0, 1'b0, 1'b1);
      drive(1, 2'd1, 32'hA1, 1'b0, 1'b1);
      drive(2, 2'd2, 32'hA2, 1'b0, 1'b1);
      tick();
      idle_src();
      check("rr_first_idx", cidx, 0);
      tick();
      check("rr_second_idx", cidx, 1);
      tick();
      check("rr_third_idx", cidx, 2);
      tick();
      check("rr_idle_valid", cv, 0);
      drive(1, 2'd3, 32'hB1, 1'b0, 1'b1);
      drive(2, 2'd1, 32'hB2, 1'b0, 1'b1);
      tick();
      idle_src();
      check("rr_wrap_first_data", cdata, 32'hB1);
      tick();
      check("rr_wrap_second_data", cdata, 32'hB2);
      wait_drain("rr", 10);

      // Backpressure: src 2 data 1..6 alongside sources 0 and 1
      do_reset();
      run_streams(6, 1'b1);

      // Fairness under saturation: 30 completions, 10 per source
      do_reset();
      run_streams(10, 1'b0);

      // Exception flag
      do_reset();
      drive(1, 2'd3, 32'h0, 1'b1, 1'b1);
      tick();
      drive(1, 2'd1, 32'h55, 1'b0, 1'b1);
      check("excp_valid", cv, 1);
      check("excp_set", cexcp, 1);
      tick();
      idle_src();
      check("excp_next_valid", cv, 1);
      check("excp_next_clear", cexcp, 0);
      wait_drain("excp", 10);

      // Reset mid-operation: pre-reset entries must never complete
      do_reset();
      drive(0, 2'd0, 32'hBAD0, 1'b0, 1'b1);
      drive(1, 2'd1, 32'hBAD1, 1'b0, 1'b0);
      drive(2, 2'd2, 32'hBAD2, 1'b0, 1'b0);
      tick();
      drive(0, 2'd3, 32'hBAD8, 1'b0, 1'b0);
      drive(1, 2'd3, 32'hBAD9, 1'b0, 1'b0);
      drive(2, 2'd3, 32'hBADA, 1'b0, 1'b0);
      tick();
      idle_src();
      check("mid_ready_full", src_ready, 3'b001);
      check("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_valid", cv, 0);
      check("mid_busy", busy, 0);
      check("mid_ready", src_ready, 3'b111);
      check("mid_data", cdata, 0);
      check("mid_queue_empty", exp_q.size(), 0);
      repeat (6) tick();
      drive(2, 2'd1, 32'h600D, 1'b0, 1'b1);
      tick();
      idle_src();
      check("mid_post_valid", cv, 1);
      wait_drain("mid", 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/completion_arbiter.md
# completion_arbiter

Collects result writebacks from several functional units, each tagged with a reorder-buffer entry index, and serializes them onto the single completion port of the reorder buffer. That port accepts one completion per cycle and has no backpressure. Each source has a small FIFO with a valid/ready handshake. FIFO heads are granted round-robin, one per cycle, and the grant drives the ROB completion inputs directly.

## Interface
- NUM_SRC, 3: number of functional-unit sources; must be at least 2.
- FIFO_DEPTH, 2: entries per source FIFO; must be a power of two and at least 2.
- ROB_ENTRY_WIDTH, 2: width of the ROB index tag.
- DATA_WIDTH, 32: result data width.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- src_valid_i  input  NUM_SRC  per-source result valid.
- src_ready_o  output  NUM_SRC  per-source FIFO can accept.
- src_idx_i  input  NUM_SRC x ROB_ENTRY_WIDTH  per-source ROB index.
- src_data_i  input  NUM_SRC x DATA_WIDTH  per-source result data.
- src_excp_i  input  NUM_SRC  per-source exception flag.
- complete_valid_o  output  1  completion valid, to the ROB's completion-valid input.
- complete_idx_o  output  ROB_ENTRY_WIDTH  completing ROB index.
- complete_data_o  output  DATA_WIDTH  completing data.
- complete_excp_o  output  1  completing exception flag.
- busy_o  output  1  at least one FIFO is non-empty.

## Operation
- **Per-source FIFO state:** storage of {idx, data, excp}, a read pointer, a write pointer, and an occupancy count of width $clog2(FIFO_DEPTH)+1.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH.
- **Ready:** src_ready_o[s] = (count_q[s] != FIFO_DEPTH). It depends on registered state only, so there is no same-cycle pop credit.
- **Push:** occurs when src_valid_i[s] and src_ready_o[s] are both high. The source must hold valid and payload stable until ready. Valid while not ready is ignored, with no state change.
- **Arbitration state:** round-robin pointer rr_q of width $clog2(NUM_SRC).
- **Search order:** rr_q, rr_q+1, … modulo NUM_SRC. The first non-empty FIFO wins.
- **Grant:** when any FIFO is non-empty, exactly one grant is issued per cycle. The winner's head drives complete_idx_o, complete_data_o and complete_excp_o, and complete_valid_o=1. The winner's FIFO pops at the clock edge, and rr_d = (winner+1) mod NUM_SRC.
- **No grant:** complete_valid_o=0, idx/data/excp outputs are 0, and rr_q is held.
- **Push and pop in the same cycle on one FIFO:** count is unchanged and both pointers advance. This is legal only when the FIFO is not full, per the ready rule.
- **Output path:** outputs are combinational from registered FIFO heads and rr_q. There is no combinational path from any src_*_i input to any complete_* output.
- **busy_o:** the OR of (count_q[s] != 0) over all sources.
- **Reset (rst_i=0 at a rising edge):**
  - all counts and pointers, and rr_q, are set to 0;
  - FIFO storage is cleared to 0;
  - result after reset: complete_valid_o=0, complete_idx_o=0, complete_data_o=0, complete_excp_o=0, busy_o=0, and src_ready_o all 1.
  - In-flight results are discarded. Reset mid-operation is legal.
- **Not checked by this block:** uniqueness of ROB indices; the allocating side guarantees it.

## Timing
- **Latency:** a result accepted in cycle N, into an empty system, appears on complete_* during cycle N+1. The ROB samples it at the end of N+1.
- **Throughput:** one completion per cycle in aggregate, and up to one push per source per cycle.
- **Per-source sustained rate:** with all sources saturated, each source completes once every NUM_SRC cycles.
- **Ready recovery:** a full FIFO that pops in cycle N shows ready=1 in cycle N+1.
- **Fairness:** a non-empty source waits at most NUM_SRC-1 cycles for its grant.
- **Ordering:** within a source, completions are strictly FIFO. Across sources there is no ordering guarantee; the ROB reorders.

## Test plan
- **Reset values:** hold rst_i=0 for 2 cycles, then release. Check all complete_* = 0, busy_o=0 and src_ready_o=3'b111. Then apply src 0 push {idx=2, data=0xDEADBEEF, excp=0} in cycle 1. Check complete_valid_o=1, idx=2, data=0xDEADBEEF in cycle 2, and busy_o=0 in cycle 3.
- **Simultaneous push / round-robin:** from reset (rr=0), push all three sources in one cycle with idx 0, 1, 2. Check completions over three consecutive cycles in order idx 0, 1, 2. Then push sources 1 and 2 together (rr=0 again after wrap). Check grants go to 1, then 2.
- **Backpressure:** drive src 2 valid continuously with data 1…6 while sources 0 and 1 also stream. Check src_ready_o[2] drops to 0 when count reaches 2. Check no payload is lost or duplicated, and that src 2 data emerges as 1…6 in order.
- **Fairness under saturation:** all sources valid every cycle for 30 cycles. Check the grant sequence is 0, 1, 2, 0, 1, 2, …, with exactly 10 completions per source and complete_valid_o=1 every cycle after the first.
- **Exception flag:** push src 1 {idx=3, data=0, excp=1}. Check complete_excp_o=1 for exactly that cycle and 0 on the next completion, which has excp=0.
- **Reset mid-operation:** fill all FIFOs, then assert rst_i=0 for one cycle. Check that in the next cycle complete_valid_o=0, busy_o=0 and ready is all 1. Check that none of the pre-reset entries ever appears on the completion port.
